// File: rtl/multi_point_tracker_if.sv
// Move-request handshake between the move decoder (master) and multi_point_tracker (slave).
interface multi_point_tracker_if #(
    parameter int W     = 3,
    parameter int SEL_W = 3
);
    logic             mv_valid;
    logic             mv_ready;
    logic             wrap;
    logic [SEL_W-1:0] mv_sel;
    logic [W-1:0]     mv_dx;
    logic [W-1:0]     mv_dy;

    modport master (output mv_valid, wrap, mv_sel, mv_dx, mv_dy, input mv_ready);
    modport slave  (input mv_valid, wrap, mv_sel, mv_dx, mv_dy, output mv_ready);
endinterface

// File: rtl/multi_point_tracker.sv
// Tracks NUM_PTS token positions on a MIN..MAX grid; applies one clamp/wrap move per 3 cycles.
// Define MP_COLLISION_EN to reject moves that land on another token's square.
module multi_point_tracker #(
    parameter int NUM_PTS = 2,
    parameter int W       = 3,
    parameter int MIN     = 1,
    parameter int MAX     = 5,
    parameter int SEL_W   = 3
) (
    input  logic                   update,
    input  logic                   rst,
    input  logic                   en,
    multi_point_tracker_if.slave   mv,
    output logic                   done,
    output logic                   blocked,
    output logic                   err,
    output logic [NUM_PTS*W-1:0]   pos_x,
    output logic [NUM_PTS*W-1:0]   pos_y
);
    localparam int SPAN = MAX - MIN + 1;
    localparam logic signed [W+1:0] MIN_S  = (W+2)'(MIN);
    localparam logic signed [W+1:0] MAX_S  = (W+2)'(MAX);
    localparam logic signed [W+1:0] SPAN_S = (W+2)'(SPAN);

    typedef enum logic [1:0] {IDLE, CALC, CHECK} state_t;

    state_t                      state_q, state_d;
    logic [SEL_W-1:0]            sel_q, sel_d;
    logic [W-1:0]                dx_q, dx_d, dy_q, dy_d;
    logic [W-1:0]                tx_q, tx_d, ty_q, ty_d;
    logic                        wrap_q, wrap_d, bad_q, bad_d;
    logic [NUM_PTS-1:0][W-1:0]   x_q, x_d, y_q, y_d;
    logic                        done_q, done_d, blocked_q, blocked_d, err_q, err_d;

    logic                        ready, sel_ok, hit;
    logic [W-1:0]                cur_x, cur_y;
    logic signed [W+1:0]         sdx, sdy, sx, sy;

    function automatic logic [W-1:0] rst_x(int k);
        return W'(MIN + ((1 + 2*k) % SPAN));
    endfunction

    function automatic logic [W-1:0] rst_y(int k);
        return W'(MAX - ((1 + 2*k) % SPAN));
    endfunction

    // Single correction only: wrap-mode displacements beyond SPAN are flagged as errors instead.
    function automatic logic [W-1:0] fix(logic signed [W+1:0] t, logic wr);
        if (t > MAX_S) return wr ? W'(t - SPAN_S) : W'(MAX_S);
        if (t < MIN_S) return wr ? W'(t + SPAN_S) : W'(MIN_S);
        return W'(t);
    endfunction

    function automatic logic signed [W+1:0] absv(logic signed [W+1:0] v);
        return (v < 0) ? -v : v;
    endfunction

    assign ready       = en && (state_q == IDLE);
    assign mv.mv_ready = ready;
    assign done        = done_q && en;
    assign blocked     = blocked_q;
    assign err         = err_q;
    assign pos_x       = x_q;
    assign pos_y       = y_q;

    assign sel_ok = int'(sel_q) < NUM_PTS;
    assign sdx    = (W+2)'($signed(dx_q));
    assign sdy    = (W+2)'($signed(dy_q));
    assign sx     = $signed({2'b00, cur_x});
    assign sy     = $signed({2'b00, cur_y});

    always_comb begin
        cur_x = '0;
        cur_y = '0;
        for (int k = 0; k < NUM_PTS; k++) begin
            if (sel_q == SEL_W'(k)) begin
                cur_x = x_q[k];
                cur_y = y_q[k];
            end
        end
    end

    always_comb begin
        hit = 1'b0;
`ifdef MP_COLLISION_EN
        for (int k = 0; k < NUM_PTS; k++) begin
            if (sel_q != SEL_W'(k) && x_q[k] == tx_q && y_q[k] == ty_q) hit = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        wrap_d    = wrap_q;
        tx_d      = tx_q;
        ty_d      = ty_q;
        bad_d     = bad_q;
        x_d       = x_q;
        y_d       = y_q;
        done_d    = 1'b0;
        blocked_d = blocked_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (mv.mv_valid && ready) begin
                    sel_d   = mv.mv_sel;
                    dx_d    = mv.mv_dx;
                    dy_d    = mv.mv_dy;
                    wrap_d  = mv.wrap;
                    state_d = CALC;
                end
            end
            CALC: begin
                tx_d    = fix(sx + sdx, wrap_q);
                ty_d    = fix(sy + sdy, wrap_q);
                bad_d   = !sel_ok || (wrap_q && (absv(sdx) > SPAN_S || absv(sdy) > SPAN_S));
                state_d = CHECK;
            end
            CHECK: begin
                done_d    = 1'b1;
                err_d     = bad_q;
                blocked_d = bad_q || hit;
                if (!bad_q && !hit) begin
                    for (int k = 0; k < NUM_PTS; k++) begin
                        if (sel_q == SEL_W'(k)) begin
                            x_d[k] = tx_q;
                            y_d[k] = ty_q;
                        end
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge update) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            wrap_q    <= 1'b0;
            tx_q      <= '0;
            ty_q      <= '0;
            bad_q     <= 1'b0;
            done_q    <= 1'b0;
            blocked_q <= 1'b0;
            err_q     <= 1'b0;
            for (int k = 0; k < NUM_PTS; k++) begin
                x_q[k] <= rst_x(k);
                y_q[k] <= rst_y(k);
            end
        end else if (en) begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            wrap_q    <= wrap_d;
            tx_q      <= tx_d;
            ty_q      <= ty_d;
            bad_q     <= bad_d;
            done_q    <= done_d;
            blocked_q <= blocked_d;
            err_q     <= err_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end
endmodule

// File: tb/tb_multi_point_tracker.sv
// Directed moves into two tracker instances (default grid, and a 1..2 grid); a monitor scores each done.
module tb_multi_point_tracker;
    logic update = 1'b0;
    logic rst, en;
    logic done0, blocked0, err0, done1, blocked1, err1;
    logic [5:0] pos_x0, pos_y0, pos_x1, pos_y1;
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] px, py;
        logic       blk, er;
        int         cyc;
    } exp_t;

    exp_t q0[$], q1[$];
    exp_t emon;
    logic [2:0] mx[2][2], my[2][2];

    multi_point_tracker_if #(.W(3), .SEL_W(3)) if0 ();
    multi_point_tracker_if #(.W(3), .SEL_W(3)) if1 ();

    multi_point_tracker #(.NUM_PTS(2), .W(3), .MIN(1), .MAX(5), .SEL_W(3)) dut0 (
        .update(update), .rst(rst), .en(en), .mv(if0), .done(done0),
        .blocked(blocked0), .err(err0), .pos_x(pos_x0), .pos_y(pos_y0));

    multi_point_tracker #(.NUM_PTS(2), .W(3), .MIN(1), .MAX(2), .SEL_W(3)) dut1 (
        .update(update), .rst(rst), .en(en), .mv(if1), .done(done1),
        .blocked(blocked1), .err(err1), .pos_x(pos_x1), .pos_y(pos_y1));

    always #5 update = ~update;
    always @(posedge update) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mx[0][0] = 3'd2; my[0][0] = 3'd4; mx[0][1] = 3'd4; my[0][1] = 3'd2;
        mx[1][0] = 3'd2; my[1][0] = 3'd1; mx[1][1] = 3'd2; my[1][1] = 3'd1;
    endtask

    always @(negedge update) begin
        if (done0) begin
            if (q0.size() == 0) chk("dut0_spurious_done", 1, 0);
            else begin
                emon = q0.pop_front();
                chk("dut0_pos_x", int'(pos_x0), int'(emon.px));
                chk("dut0_pos_y", int'(pos_y0), int'(emon.py));
                chk("dut0_blocked", int'(blocked0), int'(emon.blk));
                chk("dut0_err", int'(err0), int'(emon.er));
                chk("dut0_done_cycle", cyc, emon.cyc);
            end
        end
        if (done1) begin
            if (q1.size() == 0) chk("dut1_spurious_done", 1, 0);
            else begin
                emon = q1.pop_front();
                chk("dut1_pos_x", int'(pos_x1), int'(emon.px));
                chk("dut1_pos_y", int'(pos_y1), int'(emon.py));
                chk("dut1_blocked", int'(blocked1), int'(emon.blk));
                chk("dut1_err", int'(err1), int'(emon.er));
                chk("dut1_done_cycle", cyc, emon.cyc);
            end
        end
    end

    // ex/ey: hand-computed destination, ignored when blk is set
    task automatic move(input int d, input int sel, input int dx, input int dy, input bit wr,
                        input int ex, input int ey, input bit blk, input bit er, input int hold);
        exp_t e;
        int n = 0;
        int c;
        @(negedge update);
        while (!(d == 0 ? if0.mv_ready : if1.mv_ready) && n < 20) begin
            @(negedge update);
            n++;
        end
        if (n >= 20) begin
            chk("ready_timeout", n, 0);
            return;
        end
        if (d == 0) begin
            if0.mv_valid = 1'b1; if0.mv_sel = 3'(sel); if0.mv_dx = 3'(dx); if0.mv_dy = 3'(dy); if0.wrap = wr;
        end else begin
            if1.mv_valid = 1'b1; if1.mv_sel = 3'(sel); if1.mv_dx = 3'(dx); if1.mv_dy = 3'(dy); if1.wrap = wr;
        end
        @(posedge update);
        #1;
        c = cyc;
        if0.mv_valid = 1'b0;
        if1.mv_valid = 1'b0;
        if (!blk) begin
            mx[d][sel] = 3'(ex);
            my[d][sel] = 3'(ey);
        end
        e.px = {mx[d][1], mx[d][0]};
        e.py = {my[d][1], my[d][0]};
        e.blk = blk;
        e.er = er;
        e.cyc = c + 2 + hold;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        if (hold > 0) begin
            @(posedge update);
            @(negedge update);
            en = 1'b0;
            repeat (hold) @(posedge update);
            @(negedge update);
            en = 1'b1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 30) begin
            @(negedge update);
            n++;
        end
        chk("pending_moves", q0.size() + q1.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pos_x0"}, int'(pos_x0), 34);
        chk({tag, "_pos_y0"}, int'(pos_y0), 20);
        chk({tag, "_pos_x1"}, int'(pos_x1), 18);
        chk({tag, "_pos_y1"}, int'(pos_y1), 9);
        chk({tag, "_done"}, int'(done0), 0);
        chk({tag, "_ready"}, int'(if0.mv_ready), 1);
        chk({tag, "_blocked"}, int'(blocked0), 0);
    endtask

    task automatic pulse_reset();
        @(negedge update);
        rst = 1'b1;
        @(posedge update);
        @(negedge update);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        en = 1'b1;
        if0.mv_valid = 1'b0; if0.mv_sel = '0; if0.mv_dx = '0; if0.mv_dy = '0; if0.wrap = 1'b0;
        if1.mv_valid = 1'b0; if1.mv_sel = '0; if1.mv_dx = '0; if1.mv_dy = '0; if1.wrap = 1'b0;
        model_reset();
        @(posedge update);
        @(negedge update);
        rst = 1'b0;
        check_reset_state("reset");

        // clamp, then wrap
        move(0, 0,  3,  3, 1'b0, 5, 5, 1'b0, 1'b0, 0);
        move(0, 0, -4, -4, 1'b0, 1, 1, 1'b0, 1'b0, 0);
        move(0, 1,  2, -2, 1'b1, 1, 5, 1'b0, 1'b0, 0);
        move(0, 1, -2,  1, 1'b1, 4, 1, 1'b0, 1'b0, 0);
        drain();
        pulse_reset();

`ifdef MP_COLLISION_EN
        move(0, 0, 2, -2, 1'b0, 2, 4, 1'b1, 1'b0, 0);
`else
        move(0, 0, 2, -2, 1'b0, 4, 2, 1'b0, 1'b0, 0);
`endif
        move(0, 2,  1,  1, 1'b0, 0, 0, 1'b1, 1'b1, 0);
        move(0, 1,  0,  0, 1'b0, 4, 2, 1'b0, 1'b0, 0);
        move(0, 1,  3,  3, 1'b0, 5, 5, 1'b0, 1'b0, 0);
        move(0, 1,  1,  0, 1'b0, 5, 5, 1'b0, 1'b0, 0);
        move(0, 1, -1, -1, 1'b0, 4, 4, 1'b0, 1'b0, 2);

        // small grid: wrap displacement beyond SPAN, then legal wraps
        move(1, 0,  3,  0, 1'b1, 0, 0, 1'b1, 1'b1, 0);
        move(1, 0, -1,  0, 1'b1, 1, 1, 1'b0, 1'b0, 0);
        move(1, 1, -2,  1, 1'b1, 2, 2, 1'b0, 1'b0, 0);
        drain();

        // reset while the move sits in CALC: no done, positions back to reset
        @(negedge update);
        if0.mv_valid = 1'b1; if0.mv_sel = 3'd0; if0.mv_dx = 3'd1; if0.mv_dy = 3'd0; if0.wrap = 1'b0;
        @(posedge update);
        #1;
        if0.mv_valid = 1'b0;
        @(negedge update);
        rst = 1'b1;
        @(posedge update);
        @(negedge update);
        rst = 1'b0;
        model_reset();
        check_reset_state("midreset");
        repeat (6) @(negedge update);
        chk("midreset_no_done", int'(done0), 0);

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
